// File: rtl/param_updown_counter_pkg.sv
// +--------------------------------------------------------------------+
// | param_updown_counter_pkg: shared constants and step decode helper. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package param_updown_counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SAT      = 1;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } step_e;

  // Load outranks enable; enable outranks hold.
  function automatic step_e decode_step(input logic load, input logic en, input logic up);
    step_e step;
    if (load) begin
      step = STEP_LOAD;
    end else if (en) begin
      step = up ? STEP_UP : STEP_DOWN;
    end else begin
      step = STEP_HOLD;
    end
    return step;
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_updown_counter_if.sv
// +--------------------------------------------------------------------+
// | param_updown_counter_if: control inputs and status outputs.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface param_updown_counter_if
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             sat;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, up, load, load_val,
    input  count, wrap, sat, at_max, at_min
  );

  modport slave (
    input  en, up, load, load_val,
    output count, wrap, sat, at_max, at_min
  );

endinterface

`default_nettype wire

// File: rtl/param_updown_counter_next.sv
// +--------------------------------------------------------------------+
// | updown_next_state: combinational next count / wrap / sat decision. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module updown_next_state
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             sat_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             sat_o
);

  // One extra bit keeps MODULUS == 2**WIDTH representable.
  localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] ZERO_EXT = '0;
  localparam bit             SAT_MODE = (SATURATE == MODE_SAT);

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] next_ext;
  step_e          step;

  assign count_ext = {1'b0, count_i};
  assign load_ext  = {1'b0, load_val_i};
  assign step      = decode_step(load_i, en_i, up_i);

  always_comb begin
    next_ext = count_ext;
    wrap_o   = 1'b0;
    sat_o    = sat_i;
    case (step)
      STEP_LOAD: begin
        next_ext = (load_ext >= MOD_EXT) ? MAX_EXT : load_ext;
        sat_o    = 1'b0;
      end
      STEP_UP: begin
        if (count_ext == MAX_EXT) begin
          if (SAT_MODE) begin
            sat_o = 1'b1;
          end else begin
            next_ext = ZERO_EXT;
            wrap_o   = 1'b1;
            sat_o    = 1'b0;
          end
        end else begin
          next_ext = count_ext + ONE_EXT;
          sat_o    = 1'b0;
        end
      end
      STEP_DOWN: begin
        if (count_ext == ZERO_EXT) begin
          if (SAT_MODE) begin
            sat_o = 1'b1;
          end else begin
            next_ext = MAX_EXT;
            wrap_o   = 1'b1;
            sat_o    = 1'b0;
          end
        end else begin
          next_ext = count_ext - ONE_EXT;
          sat_o    = 1'b0;
        end
      end
      default: begin
        next_ext = count_ext;
      end
    endcase
    count_o = WIDTH'(next_ext);
  end

endmodule

`default_nettype wire

// File: rtl/param_updown_counter.sv
// +--------------------------------------------------------------------+
// | param_updown_counter: count/wrap/sat registers and boundary flags. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  param_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             sat_q;
  logic             sat_d;

  updown_next_state #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .count_i    (count_q),
    .sat_i      (sat_q),
    .en_i       (bus.en),
    .up_i       (bus.up),
    .load_i     (bus.load),
    .load_val_i (bus.load_val),
    .count_o    (count_d),
    .wrap_o     (wrap_d),
    .sat_o      (sat_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.wrap   = wrap_q;
  assign bus.sat    = sat_q;
  assign bus.at_max = (count_q == MAX_VAL);
  assign bus.at_min = (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_param_updown_counter.sv
// +--------------------------------------------------------------------+
// | tb_param_updown_counter: scoreboard bench over three configurations.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_param_updown_counter;
  import param_updown_counter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 0: MODULUS 10 wrap, 1: MODULUS 10 saturate, 2: MODULUS 16 wrap
  param_updown_counter_if #(.WIDTH(4)) bw ();
  param_updown_counter_if #(.WIDTH(4)) bs ();
  param_updown_counter_if #(.WIDTH(4)) bf ();

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(MODE_WRAP)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bw));
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(MODE_SAT)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bs));
  param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(MODE_WRAP)) dut_full (
    .clk(clk), .rst_n(rst_n), .bus(bf));

  typedef struct {
    int         d;
    logic [3:0] c;
    logic       w;
    logic       s;
    string      name;
  } exp_t;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lv;
    logic [3:0] c;
    logic       w;
    logic       s;
  } stp_t;

  typedef struct {
    logic [3:0] c;
    logic       w;
    logic       s;
  } st_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   mods[3]  = '{10, 10, 16};
  bit   satm[3]  = '{1'b0, 1'b1, 1'b0};

  function automatic logic [7:0] get_act(input int d);
    case (d)
      0:       return {bw.count, bw.wrap, bw.sat, bw.at_max, bw.at_min};
      1:       return {bs.count, bs.wrap, bs.sat, bs.at_max, bs.at_min};
      default: return {bf.count, bf.wrap, bf.sat, bf.at_max, bf.at_min};
    endcase
  endfunction

  function automatic logic [7:0] pack_exp(input exp_t e);
    logic mx;
    logic mn;
    mx = (e.c == 4'(mods[e.d] - 1));
    mn = (e.c == 4'd0);
    return {e.c, e.w, e.s, mx, mn};
  endfunction

  function automatic st_t model(input st_t s, input int m, input bit sm,
                                input logic en, input logic up, input logic load,
                                input logic [3:0] lv);
    st_t n;
    n   = s;
    n.w = 1'b0;
    if (load) begin
      n.c = (int'(lv) >= m) ? 4'(m - 1) : lv;
      n.s = 1'b0;
    end else if (en) begin
      if (up && int'(s.c) == m - 1) begin
        if (sm) n.s = 1'b1;
        else begin n.c = 4'd0; n.w = 1'b1; end
      end else if (!up && s.c == 4'd0) begin
        if (sm) n.s = 1'b1;
        else begin n.c = 4'(m - 1); n.w = 1'b1; end
      end else begin
        n.c = up ? s.c + 4'd1 : s.c - 4'd1;
        n.s = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic drive(input int d, input logic en, input logic up,
                       input logic load, input logic [3:0] lv);
    case (d)
      0:       begin bw.en = en; bw.up = up; bw.load = load; bw.load_val = lv; end
      1:       begin bs.en = en; bs.up = up; bs.load = load; bs.load_val = lv; end
      default: begin bf.en = en; bf.up = up; bf.load = load; bf.load_val = lv; end
    endcase
  endtask

  task automatic push(input int d, input logic [3:0] c, input logic w,
                      input logic s, input string name);
    exp_t e;
    e.d = d; e.c = c; e.w = w; e.s = s; e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    exp_t       e;
    logic [7:0] act;
    logic [7:0] exv;
    idle_all();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    for (int d = 0; d < 3; d++) push(d, 4'd0, 1'b0, 1'b0, "reset_state");
    while (sb.size() > 0) begin
      e = sb.pop_front(); act = get_act(e.d); exv = pack_exp(e); n_vec++;
      if (act !== exv) begin
        n_bad++;
        $display("FAIL %s dut%0d: got cnt/wrap/sat/max/min=%b required %b", e.name, e.d, act, exv);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    exp_t       e;
    logic [7:0] act;
    logic [7:0] exv;
    for (int ph = 0; ph < 3; ph++) begin
      @(negedge clk);
      if (ph == 0) begin
        drive(0, 1'b0, 1'b0, 1'b1, 4'd7);
        drive(1, 1'b0, 1'b0, 1'b1, 4'd9);
        push(0, 4'd7, 1'b0, 1'b0, "areset_load7");
        push(1, 4'd9, 1'b0, 1'b0, "areset_load9");
        @(posedge clk); @(negedge clk);
      end else if (ph == 1) begin
        drive(0, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1, 1'b1, 1'b1, 1'b0, 4'd0);
        push(0, 4'd7, 1'b0, 1'b0, "areset_hold7");
        push(1, 4'd9, 1'b0, 1'b1, "areset_satset");
        @(posedge clk); @(negedge clk);
      end else begin
        idle_all();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) push(d, 4'd0, 1'b0, 1'b0, "areset_midcycle");
      end
      while (sb.size() > 0) begin
        e = sb.pop_front(); act = get_act(e.d); exv = pack_exp(e); n_vec++;
        if (act !== exv) begin
          n_bad++;
          $display("FAIL %s dut%0d: got cnt/wrap/sat/max/min=%b required %b", e.name, e.d, act, exv);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    stp_t       t[$];
    exp_t       e;
    logic [7:0] act;
    logic [7:0] exv;
    t.push_back('{1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0});
    for (int i = 1; i <= 12; i++)
      t.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4'(i % 10), (i == 10), 1'b0});
    foreach (t[k]) begin
      drive(0, t[k].en, t[k].up, t[k].load, t[k].lv);
      push(0, t[k].c, t[k].w, t[k].s, "wrap_up");
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); act = get_act(e.d); exv = pack_exp(e); n_vec++;
        if (act !== exv) begin
          n_bad++;
          $display("FAIL %s step%0d: got cnt/wrap/sat/max/min=%b required %b", e.name, k, act, exv);
        end
      end
    end
    idle_all();
  endtask

  task automatic test_wrap_down();
    stp_t       t[$];
    exp_t       e;
    logic [7:0] act;
    logic [7:0] exv;
    t.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0});
    t.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0});
    t.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0});
    t.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0});
    t.push_back('{1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0});
    foreach (t[k]) begin
      drive(0, t[k].en, t[k].up, t[k].load, t[k].lv);
      push(0, t[k].c, t[k].w, t[k].s, "wrap_down");
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); act = get_act(e.d); exv = pack_exp(e); n_vec++;
        if (act !== exv) begin
          n_bad++;
          $display("FAIL %s step%0d: got cnt/wrap/sat/max/min=%b required %b", e.name, k, act, exv);
        end
      end
    end
    idle_all();
  endtask

  task automatic test_saturate();
    stp_t       t[$];
    exp_t       e;
    logic [7:0] act;
    logic [7:0] exv;
    t.push_back('{1'b0, 1'b0, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0});
    t.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0});
    t.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1});
    t.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1});
    t.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1});
    t.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0});
    t.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0});
    t.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1});
    t.push_back('{1'b1, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0});
    foreach (t[k]) begin
      drive(1, t[k].en, t[k].up, t[k].load, t[k].lv);
      push(1, t[k].c, t[k].w, t[k].s, "saturate");
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); act = get_act(e.d); exv = pack_exp(e); n_vec++;
        if (act !== exv) begin
          n_bad++;
          $display("FAIL %s step%0d: got cnt/wrap/sat/max/min=%b required %b", e.name, k, act, exv);
        end
      end
    end
    idle_all();
  endtask

  task automatic test_load_clamp();
    stp_t       t[$];
    exp_t       e;
    logic [7:0] act;
    logic [7:0] exv;
    t.push_back('{1'b1, 1'b1, 1'b1, 4'd13, 4'd9, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++)
      t.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0});
    t.push_back('{1'b0, 1'b0, 1'b1, 4'd10, 4'd9, 1'b0, 1'b0});
    t.push_back('{1'b0, 1'b0, 1'b1, 4'd15, 4'd9, 1'b0, 1'b0});
    t.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0});
    t.push_back('{1'b1, 1'b0, 1'b1, 4'd4, 4'd4, 1'b0, 1'b0});
    foreach (t[k]) begin
      drive(0, t[k].en, t[k].up, t[k].load, t[k].lv);
      push(0, t[k].c, t[k].w, t[k].s, "load_clamp");
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); act = get_act(e.d); exv = pack_exp(e); n_vec++;
        if (act !== exv) begin
          n_bad++;
          $display("FAIL %s step%0d: got cnt/wrap/sat/max/min=%b required %b", e.name, k, act, exv);
        end
      end
    end
    idle_all();
  endtask

  task automatic test_full_range();
    stp_t       t[$];
    exp_t       e;
    logic [7:0] act;
    logic [7:0] exv;
    t.push_back('{1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 1'b0, 1'b0});
    t.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0});
    t.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 4'd15, 1'b1, 1'b0});
    t.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 4'd14, 1'b0, 1'b0});
    t.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4'd15, 1'b0, 1'b0});
    foreach (t[k]) begin
      drive(2, t[k].en, t[k].up, t[k].load, t[k].lv);
      push(2, t[k].c, t[k].w, t[k].s, "full_range");
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); act = get_act(e.d); exv = pack_exp(e); n_vec++;
        if (act !== exv) begin
          n_bad++;
          $display("FAIL %s step%0d: got cnt/wrap/sat/max/min=%b required %b", e.name, k, act, exv);
        end
      end
    end
    idle_all();
  endtask

  task automatic test_random();
    st_t        ms[3];
    exp_t       e;
    logic [7:0] act;
    logic [7:0] exv;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lv;
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 1'b0, 1'b1, 4'd0);
      ms[d] = '{4'd0, 1'b0, 1'b0};
    end
    @(posedge clk); @(negedge clk);
    for (int cyc = 0; cyc < 60; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        en = ($urandom_range(0, 3) != 0);
        up = ($urandom_range(0, 2) != 0) ^ (cyc >= 30);
        ld = ($urandom_range(0, 9) == 0);
        lv = 4'($urandom_range(0, 15));
        drive(d, en, up, ld, lv);
        ms[d] = model(ms[d], mods[d], satm[d], en, up, ld, lv);
        push(d, ms[d].c, ms[d].w, ms[d].s, "random");
      end
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); act = get_act(e.d); exv = pack_exp(e); n_vec++;
        if (act !== exv) begin
          n_bad++;
          $display("FAIL %s dut%0d cyc%0d: got cnt/wrap/sat/max/min=%b required %b", e.name, e.d, cyc, act, exv);
        end
      end
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_clamp();
    test_full_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
